// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
// ----------------------------------------------------------------------------
// Two-master / one-slave arbiter for the AXI-lite read path (AR + R).
// Master 0 is the IFU fetch port and master 1 is the LSU load port. The slave
// side feeds the pmem read bridge. The grant is held from AR issue until the
// final R beat (RLAST) handshakes, so slave responses never interleave.
//
// Parameters:
//   ADDR_W          address width on every AR channel
//   DATA_W          R data width
//   FIXED_PRIO      0 = round-robin on a tie, 1 = master 1 always wins a tie
//   TIMEOUT_CYCLES  R-wait limit, only meaningful with ARB_TIMEOUT_EN
//
// Optional build macro:
//   ARB_TIMEOUT_EN  adds an R-wait watchdog. After TIMEOUT_CYCLES DATA cycles
//                   without slave data, the granted master gets a single
//                   SLVERR beat (RLAST=1, RDATA=0) and the output timeout_err
//                   pulses for one cycle on that handshake.
//
// Ports:
//   ACLK, ARESET              clock, synchronous active-high reset
//   m0_AR*, m1_AR*            master address requests / ARREADY back
//   m0_R*, m1_R*              read data returned to masters / RREADY in
//   s_AR*, s_R*               slave-side AR and R channels
//   grant                     one-hot owner (bit0 = m0), 2'b00 when idle
//   busy                      high in ADDR or DATA state
//   timeout_err               watchdog pulse (ARB_TIMEOUT_EN builds only)
// ----------------------------------------------------------------------------
module axi_rd_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 64,
  parameter int FIXED_PRIO     = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              m0_ARVALID,
  input  logic [ADDR_W-1:0] m0_ARADDR,
  input  logic [2:0]        m0_ARPROT,
  output logic              m0_ARREADY,
  output logic              m0_RVALID,
  output logic [DATA_W-1:0] m0_RDATA,
  output logic              m0_RLAST,
  output logic [1:0]        m0_RRESP,
  input  logic              m0_RREADY,
  input  logic              m1_ARVALID,
  input  logic [ADDR_W-1:0] m1_ARADDR,
  input  logic [2:0]        m1_ARPROT,
  output logic              m1_ARREADY,
  output logic              m1_RVALID,
  output logic [DATA_W-1:0] m1_RDATA,
  output logic              m1_RLAST,
  output logic [1:0]        m1_RRESP,
  input  logic              m1_RREADY,
  output logic              s_ARVALID,
  output logic [ADDR_W-1:0] s_ARADDR,
  output logic [2:0]        s_ARPROT,
  input  logic              s_ARREADY,
  input  logic              s_RVALID,
  input  logic [DATA_W-1:0] s_RDATA,
  input  logic              s_RLAST,
  input  logic [1:0]        s_RRESP,
  output logic              s_RREADY,
`ifdef ARB_TIMEOUT_EN
  output logic              timeout_err,
`endif
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } state_t;

  state_t            state_r, state_s;
  logic [1:0]        grant_r, grant_s;
  logic              last_owner_r, last_owner_s;   // index of the last master served
  logic              winner_s;                     // index that wins in IDLE
  logic              gnt_arvalid_s;
  logic [ADDR_W-1:0] gnt_araddr_s;
  logic [2:0]        gnt_arprot_s;
  logic              gnt_rready_s;
  logic              r_last_hs_s;
  logic              to_hit_s;                     // watchdog expired, synthesising SLVERR
  logic              to_done_s;                    // synthetic SLVERR beat accepted
  logic              rv_s;
  logic [DATA_W-1:0] rd_s;
  logic              rl_s;
  logic [1:0]        rr_s;

  // Winner selection among current requesters.
  always_comb begin
    winner_s = 1'b0;
    if (m0_ARVALID && m1_ARVALID) begin
      if (FIXED_PRIO != 0) begin
        winner_s = 1'b1;
      end else begin
        // Round-robin: whoever was not served last goes first.
        winner_s = ~last_owner_r;
      end
    end else if (m1_ARVALID) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end

  // Mux of the currently granted master's request and ready signals.
  always_comb begin
    gnt_arvalid_s = 1'b0;
    gnt_araddr_s  = '0;
    gnt_arprot_s  = 3'b000;
    gnt_rready_s  = 1'b0;
    if (grant_r[1]) begin
      gnt_arvalid_s = m1_ARVALID;
      gnt_araddr_s  = m1_ARADDR;
      gnt_arprot_s  = m1_ARPROT;
      gnt_rready_s  = m1_RREADY;
    end else if (grant_r[0]) begin
      gnt_arvalid_s = m0_ARVALID;
      gnt_araddr_s  = m0_ARADDR;
      gnt_arprot_s  = m0_ARPROT;
      gnt_rready_s  = m0_RREADY;
    end else begin
      gnt_arvalid_s = 1'b0;
    end
  end

  assign r_last_hs_s = s_RVALID && s_RREADY && s_RLAST;
  assign to_done_s   = to_hit_s && gnt_rready_s;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt_r;

  assign to_hit_s    = (state_r == ST_DATA) && (to_cnt_r == CNT_W'(TIMEOUT_CYCLES));
  assign timeout_err = to_done_s;

  // R-wait watchdog: counts DATA cycles without slave data, saturates at the limit.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      to_cnt_r <= '0;
    end else if (state_r != ST_DATA) begin
      // Held at zero outside DATA, so it starts from zero on entry.
      to_cnt_r <= '0;
    end else if (s_RVALID && s_RREADY) begin
      to_cnt_r <= '0;
    end else if (!s_RVALID && !to_hit_s) begin
      to_cnt_r <= to_cnt_r + CNT_W'(1);
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYCLES == 0);
  assign to_hit_s         = 1'b0;
`endif

  // Next-state, next-grant and round-robin pointer update.
  always_comb begin
    state_s      = state_r;
    grant_s      = grant_r;
    last_owner_s = last_owner_r;
    case (state_r)
      ST_IDLE: begin
        if (m0_ARVALID || m1_ARVALID) begin
          state_s = ST_ADDR;
          grant_s = winner_s ? 2'b10 : 2'b01;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (!gnt_arvalid_s) begin
          // Master withdrew its request: abandon without touching last_owner.
          state_s = ST_IDLE;
          grant_s = 2'b00;
        end else if (s_ARREADY) begin
          state_s = ST_DATA;
        end else begin
          state_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (r_last_hs_s || to_done_s) begin
          state_s      = ST_IDLE;
          grant_s      = 2'b00;
          last_owner_s = grant_r[1];
        end else begin
          state_s = ST_DATA;
        end
      end
      default: begin
        state_s = ST_IDLE;
        grant_s = 2'b00;
      end
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_r      <= ST_IDLE;
      grant_r      <= 2'b00;
      last_owner_r <= 1'b1;   // makes m0 win the first tie
    end else begin
      state_r      <= state_s;
      grant_r      <= grant_s;
      last_owner_r <= last_owner_s;
    end
  end

  // Channel routing: AR to the slave in ADDR, R back to the owner in DATA.
  always_comb begin
    s_ARVALID  = 1'b0;
    s_ARADDR   = '0;
    s_ARPROT   = 3'b000;
    s_RREADY   = 1'b0;
    m0_ARREADY = 1'b0;
    m1_ARREADY = 1'b0;
    rv_s       = 1'b0;
    rd_s       = '0;
    rl_s       = 1'b0;
    rr_s       = 2'b00;
    case (state_r)
      ST_ADDR: begin
        s_ARVALID = gnt_arvalid_s;
        s_ARADDR  = gnt_araddr_s;
        s_ARPROT  = gnt_arprot_s;
        if (grant_r[1]) begin
          m1_ARREADY = s_ARREADY;
        end else begin
          m0_ARREADY = s_ARREADY;
        end
      end
      ST_DATA: begin
        if (to_hit_s) begin
          // Synthetic SLVERR beat; the slave is not acknowledged.
          rv_s     = 1'b1;
          rd_s     = '0;
          rl_s     = 1'b1;
          rr_s     = 2'b10;
          s_RREADY = 1'b0;
        end else begin
          rv_s     = s_RVALID;
          rd_s     = s_RDATA;
          rl_s     = s_RLAST;
          rr_s     = s_RRESP;
          s_RREADY = gnt_rready_s;
        end
      end
      default: begin
        s_ARVALID = 1'b0;
      end
    endcase
  end

  // R outputs: only the owner sees the beat, the other master sees zeros.
  always_comb begin
    m0_RVALID = 1'b0;
    m0_RDATA  = '0;
    m0_RLAST  = 1'b0;
    m0_RRESP  = 2'b00;
    m1_RVALID = 1'b0;
    m1_RDATA  = '0;
    m1_RLAST  = 1'b0;
    m1_RRESP  = 2'b00;
    if (grant_r[1]) begin
      m1_RVALID = rv_s;
      m1_RDATA  = rd_s;
      m1_RLAST  = rl_s;
      m1_RRESP  = rr_s;
    end else if (grant_r[0]) begin
      m0_RVALID = rv_s;
      m0_RDATA  = rd_s;
      m0_RLAST  = rl_s;
      m0_RRESP  = rr_s;
    end else begin
      m0_RVALID = 1'b0;
    end
  end

  assign grant = grant_r;
  assign busy  = (state_r != ST_IDLE);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;
  localparam int AW           = 32;
  localparam int DW           = 64;
  localparam int P_FIXED_PRIO = 0;
  localparam int P_TIMEOUT    = 8;
  localparam logic [31:0] A0  = 32'hA000_0010;
  localparam logic [31:0] A1  = 32'hB000_0020;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          m0_ARVALID, m1_ARVALID, m0_ARREADY, m1_ARREADY;
  logic [AW-1:0] m0_ARADDR, m1_ARADDR, s_ARADDR;
  logic [2:0]    m0_ARPROT, m1_ARPROT, s_ARPROT;
  logic          m0_RVALID, m1_RVALID, m0_RLAST, m1_RLAST, m0_RREADY, m1_RREADY;
  logic [DW-1:0] m0_RDATA, m1_RDATA, s_RDATA;
  logic [1:0]    m0_RRESP, m1_RRESP, s_RRESP, grant;
  logic          s_ARVALID, s_ARREADY, s_RVALID, s_RLAST, s_RREADY, busy;
`ifdef ARB_TIMEOUT_EN
  logic          timeout_err;
`endif

  axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(P_FIXED_PRIO),
                   .TIMEOUT_CYCLES(P_TIMEOUT)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .m0_ARVALID(m0_ARVALID), .m0_ARADDR(m0_ARADDR), .m0_ARPROT(m0_ARPROT),
    .m0_ARREADY(m0_ARREADY), .m0_RVALID(m0_RVALID), .m0_RDATA(m0_RDATA),
    .m0_RLAST(m0_RLAST), .m0_RRESP(m0_RRESP), .m0_RREADY(m0_RREADY),
    .m1_ARVALID(m1_ARVALID), .m1_ARADDR(m1_ARADDR), .m1_ARPROT(m1_ARPROT),
    .m1_ARREADY(m1_ARREADY), .m1_RVALID(m1_RVALID), .m1_RDATA(m1_RDATA),
    .m1_RLAST(m1_RLAST), .m1_RRESP(m1_RRESP), .m1_RREADY(m1_RREADY),
    .s_ARVALID(s_ARVALID), .s_ARADDR(s_ARADDR), .s_ARPROT(s_ARPROT),
    .s_ARREADY(s_ARREADY), .s_RVALID(s_RVALID), .s_RDATA(s_RDATA),
    .s_RLAST(s_RLAST), .s_RRESP(s_RRESP), .s_RREADY(s_RREADY),
`ifdef ARB_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .grant(grant), .busy(busy)
  );

  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Drive just after the active edge, observe on the falling edge.
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic samp();
    @(negedge ACLK);
  endtask

  task automatic clear_inputs();
    m0_ARVALID = 1'b0; m0_ARADDR = '0; m0_ARPROT = 3'd0; m0_RREADY = 1'b0;
    m1_ARVALID = 1'b0; m1_ARADDR = '0; m1_ARPROT = 3'd0; m1_RREADY = 1'b0;
    s_ARREADY = 1'b0; s_RVALID = 1'b0; s_RDATA = '0; s_RLAST = 1'b0; s_RRESP = 2'b00;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    clear_inputs();
    step();
    ARESET = 1'b0;
  endtask

  function automatic logic [1:0] onehot(input int idx);
    return (idx == 1) ? 2'b10 : 2'b01;
  endfunction

  // Arbitration rule: lone requester wins; tie goes to m1 under fixed
  // priority, otherwise to whichever master was not served last.
  function automatic int pick(input bit r0, input bit r1, input int last);
    if (r0 && r1) return (P_FIXED_PRIO != 0) ? 1 : ((last == 1) ? 0 : 1);
    else if (r1) return 1;
    else return 0;
  endfunction

  // ---------------- randomized traffic with a transaction-level model -------
  int          mst_state[2];            // 0 idle, 1 requesting, 2 awaiting data
  logic [31:0] maddr[2];
  logic [2:0]  mprot[2];
  int          mbeat[2];
  logic        mrdy[2];
  int          slv_phase, slv_delay, slv_nbeats, slv_k, slv_zero;
  logic        slv_rv;
  logic [31:0] slv_addr;
  bit          exp_busy;
  int          exp_owner, exp_last;

  task automatic rand_cycle(input bit allow_new);
    bit in_addr, in_data, exp_rv, ar_hs, r_hs;
    logic [63:0] rd_got;
    logic rl_got;
    step();
    for (int i = 0; i < 2; i++) begin
      if (allow_new && mst_state[i] == 0 && $urandom_range(0, 2) == 0) begin
        mst_state[i] = 1;
        maddr[i] = $urandom;
        mprot[i] = 3'($urandom_range(0, 7));
      end
      mrdy[i] = ($urandom_range(0, 3) != 0);
    end
    m0_ARVALID = (mst_state[0] == 1); m0_ARADDR = maddr[0]; m0_ARPROT = mprot[0];
    m1_ARVALID = (mst_state[1] == 1); m1_ARADDR = maddr[1]; m1_ARPROT = mprot[1];
    m0_RREADY = mrdy[0]; m1_RREADY = mrdy[1];
    s_ARREADY = ($urandom_range(0, 1) != 0);
    if (slv_phase == 2 && !slv_rv)
      slv_rv = ($urandom_range(0, 2) != 0) || (slv_zero >= 3);
    s_RVALID = (slv_phase == 2) && slv_rv;
    s_RDATA  = {slv_addr, 32'(slv_k)};
    s_RLAST  = (slv_k == slv_nbeats - 1);
    s_RRESP  = 2'b00;

    samp();
    in_addr = exp_busy && (slv_phase == 0);
    in_data = exp_busy && (slv_phase != 0);
    exp_rv  = in_data && (slv_phase == 2) && s_RVALID;
    chk("rnd_grant", 64'(grant), exp_busy ? 64'(onehot(exp_owner)) : 64'd0);
    chk("rnd_busy", 64'(busy), 64'(exp_busy));
    chk("rnd_s_arvalid", 64'(s_ARVALID), 64'(in_addr));
    if (in_addr) begin
      chk("rnd_s_araddr", 64'(s_ARADDR), 64'(maddr[exp_owner]));
      chk("rnd_s_arprot", 64'(s_ARPROT), 64'(mprot[exp_owner]));
    end
    chk("rnd_m0_arready", 64'(m0_ARREADY), 64'(in_addr && exp_owner == 0 && s_ARREADY));
    chk("rnd_m1_arready", 64'(m1_ARREADY), 64'(in_addr && exp_owner == 1 && s_ARREADY));
    chk("rnd_m0_rvalid", 64'(m0_RVALID), 64'(exp_rv && exp_owner == 0));
    chk("rnd_m1_rvalid", 64'(m1_RVALID), 64'(exp_rv && exp_owner == 1));
    chk("rnd_s_rready", 64'(s_RREADY), 64'(in_data && mrdy[exp_owner]));
    ar_hs = in_addr && s_ARREADY;
    r_hs  = exp_rv && mrdy[exp_owner];
    if (r_hs) begin
      rd_got = (exp_owner == 1) ? m1_RDATA : m0_RDATA;
      rl_got = (exp_owner == 1) ? m1_RLAST : m0_RLAST;
      chk("rnd_rdata", rd_got, {maddr[exp_owner], 32'(mbeat[exp_owner])});
      chk("rnd_rlast", 64'(rl_got), 64'(mbeat[exp_owner] == slv_nbeats - 1));
    end
    // Advance bench-side agents and the model to the state after the next edge.
    if (in_data && !s_RVALID) slv_zero++;
    if (slv_phase == 1) begin
      if (slv_delay == 0) slv_phase = 2;
      else slv_delay--;
    end else if (ar_hs) begin
      mst_state[exp_owner] = 2;
      slv_phase  = 1;
      slv_delay  = $urandom_range(0, 2);
      slv_nbeats = $urandom_range(1, 4);
      slv_k      = 0;
      slv_rv     = 1'b0;
      slv_zero   = 0;
      slv_addr   = s_ARADDR;
    end
    if (r_hs) begin
      slv_k++;
      slv_rv   = 1'b0;
      slv_zero = 0;
      mbeat[exp_owner]++;
      if (mbeat[exp_owner] == slv_nbeats) begin
        mst_state[exp_owner] = 0;
        mbeat[exp_owner] = 0;
        slv_phase = 0;
        exp_busy  = 1'b0;
        exp_last  = exp_owner;
      end
    end else if (!exp_busy && (mst_state[0] == 1 || mst_state[1] == 1)) begin
      exp_busy  = 1'b1;
      exp_owner = pick(mst_state[0] == 1, mst_state[1] == 1, exp_last);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        m0v;
    logic        m1v;
    logic [1:0]  exp_grant;
    logic [31:0] exp_addr;
    logic [2:0]  exp_prot;
  } vec_t;

  vec_t        vecs[4];
  logic [1:0]  alt_exp[9];
  logic [63:0] beats[4];
  logic        rdy_pat[5];
  int          k, guard;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 2'b00, 32'h0, 3'd0};
    vecs[1] = '{1'b1, 1'b0, 2'b01, A0, 3'd1};
    vecs[2] = '{1'b0, 1'b1, 2'b10, A1, 3'd2};
    vecs[3] = '{1'b1, 1'b1, (P_FIXED_PRIO != 0) ? 2'b10 : 2'b01,
                (P_FIXED_PRIO != 0) ? A1 : A0, (P_FIXED_PRIO != 0) ? 3'd2 : 3'd1};
    if (P_FIXED_PRIO != 0) alt_exp = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10};
    else                   alt_exp = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01};
    beats   = '{64'h1111_0000_0000_0001, 64'h2222_0000_0000_0002,
                64'h3333_0000_0000_0003, 64'h4444_0000_0000_0004};
    rdy_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    // Single-cycle arbitration out of reset.
    foreach (vecs[v]) begin
      do_reset();
      m0_ARVALID = vecs[v].m0v; m0_ARADDR = A0; m0_ARPROT = 3'd1;
      m1_ARVALID = vecs[v].m1v; m1_ARADDR = A1; m1_ARPROT = 3'd2;
      samp();
      chk("vec_idle_grant", 64'(grant), 64'd0);
      chk("vec_idle_s_arvalid", 64'(s_ARVALID), 64'd0);
      step();
      samp();
      chk("vec_grant", 64'(grant), 64'(vecs[v].exp_grant));
      chk("vec_busy", 64'(busy), 64'(vecs[v].exp_grant != 2'b00));
      chk("vec_s_arvalid", 64'(s_ARVALID), 64'(vecs[v].exp_grant != 2'b00));
      chk("vec_s_araddr", 64'(s_ARADDR), 64'(vecs[v].exp_addr));
      chk("vec_s_arprot", 64'(s_ARPROT), 64'(vecs[v].exp_prot));
    end

    // m0 alone, single beat.
    do_reset();
    m0_ARVALID = 1'b1; m0_ARADDR = 32'h8000_0000; s_ARREADY = 1'b1;
    samp();
    chk("single_c0_s_arvalid", 64'(s_ARVALID), 64'd0);
    step();
    samp();
    chk("single_c1_s_arvalid", 64'(s_ARVALID), 64'd1);
    chk("single_c1_s_araddr", 64'(s_ARADDR), 64'h8000_0000);
    chk("single_c1_grant", 64'(grant), 64'(2'b01));
    chk("single_c1_m0_arready", 64'(m0_ARREADY), 64'd1);
    step();
    m0_ARVALID = 1'b0; s_ARREADY = 1'b0; m0_RREADY = 1'b1;
    s_RVALID = 1'b1; s_RDATA = 64'h1122_3344_5566_7788; s_RLAST = 1'b1;
    samp();
    chk("single_m0_rvalid", 64'(m0_RVALID), 64'd1);
    chk("single_m0_rdata", m0_RDATA, 64'h1122_3344_5566_7788);
    chk("single_m1_rvalid", 64'(m1_RVALID), 64'd0);
    chk("single_m1_rdata", m1_RDATA, 64'd0);
    chk("single_s_rready", 64'(s_RREADY), 64'd1);
    chk("single_s_arvalid_data", 64'(s_ARVALID), 64'd0);
    step();
    s_RVALID = 1'b0;
    samp();
    chk("single_end_grant", 64'(grant), 64'd0);
    chk("single_end_busy", 64'(busy), 64'd0);

    // Both masters requesting continuously: alternation with one idle bubble.
    do_reset();
    m0_ARVALID = 1'b1; m0_ARADDR = A0; m1_ARVALID = 1'b1; m1_ARADDR = A1;
    s_ARREADY = 1'b1; s_RVALID = 1'b1; s_RLAST = 1'b1; s_RDATA = 64'h5A5A;
    m0_RREADY = 1'b1; m1_RREADY = 1'b1;
    for (int c = 0; c < 9; c++) begin
      samp();
      chk($sformatf("alt_grant_c%0d", c), 64'(grant), 64'(alt_exp[c]));
      if (alt_exp[c] == 2'b01) chk("alt_m1_rvalid", 64'(m1_RVALID), 64'd0);
      if (alt_exp[c] == 2'b10) chk("alt_m0_rvalid", 64'(m0_RVALID), 64'd0);
      step();
    end

    // m1 burst of 4 beats with RREADY 1,0,1,1,1 while m0 waits.
    do_reset();
    m1_ARVALID = 1'b1; m1_ARADDR = A1; s_ARREADY = 1'b1;
    step();
    step();
    m1_ARVALID = 1'b0; s_ARREADY = 1'b0; m0_ARVALID = 1'b1; m0_ARADDR = A0;
    k = 0;
    for (int j = 0; j < 5; j++) begin
      s_RVALID = 1'b1; s_RDATA = beats[k]; s_RLAST = (k == 3); m1_RREADY = rdy_pat[j];
      samp();
      chk($sformatf("burst_m1_rdata_j%0d", j), m1_RDATA, beats[k]);
      chk("burst_m1_rvalid", 64'(m1_RVALID), 64'd1);
      chk("burst_m1_rlast", 64'(m1_RLAST), 64'(k == 3));
      chk("burst_grant", 64'(grant), 64'(2'b10));
      chk("burst_m0_arready", 64'(m0_ARREADY), 64'd0);
      chk("burst_s_rready", 64'(s_RREADY), 64'(rdy_pat[j]));
      if (rdy_pat[j]) k++;
      step();
    end
    s_RVALID = 1'b0; s_RLAST = 1'b0;
    samp();
    chk("burst_bubble_grant", 64'(grant), 64'd0);
    chk("burst_bubble_busy", 64'(busy), 64'd0);
    step();
    samp();
    chk("burst_next_grant", 64'(grant), 64'(2'b01));

    // Reset asserted mid-DATA with a beat pending.
    do_reset();
    m0_ARVALID = 1'b1; m0_ARADDR = A0; s_ARREADY = 1'b1;
    step();
    step();
    m0_ARVALID = 1'b0; s_ARREADY = 1'b0; m0_RREADY = 1'b1;
    s_RVALID = 1'b1; s_RLAST = 1'b1; s_RDATA = 64'hDEAD_BEEF; ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    samp();
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_m0_rvalid", 64'(m0_RVALID), 64'd0);
    chk("rst_m0_rdata", m0_RDATA, 64'd0);
    chk("rst_s_rready", 64'(s_RREADY), 64'd0);
    chk("rst_s_arvalid", 64'(s_ARVALID), 64'd0);
    chk("rst_arready", 64'({m0_ARREADY, m1_ARREADY}), 64'd0);
    s_RVALID = 1'b0; m1_ARVALID = 1'b1; m1_ARADDR = A1;
    step();
    samp();
    chk("rst_after_grant", 64'(grant), 64'(2'b10));
    chk("rst_after_s_araddr", 64'(s_ARADDR), 64'(A1));

    // Granted master withdraws ARVALID in ADDR: abort, pointer unchanged.
    do_reset();
    m0_ARVALID = 1'b1; m0_ARADDR = A0;
    step();
    m0_ARVALID = 1'b0;
    samp();
    chk("abort_s_arvalid", 64'(s_ARVALID), 64'd0);
    step();
    samp();
    chk("abort_grant", 64'(grant), 64'd0);
    m0_ARVALID = 1'b1; m1_ARVALID = 1'b1; m1_ARADDR = A1;
    step();
    samp();
    chk("abort_tie_grant", 64'(grant), (P_FIXED_PRIO != 0) ? 64'(2'b10) : 64'(2'b01));

`ifdef ARB_TIMEOUT_EN
    // Slave never answers: synthetic SLVERR after P_TIMEOUT DATA cycles.
    do_reset();
    m0_ARVALID = 1'b1; m0_ARADDR = A0; s_ARREADY = 1'b1; m0_RREADY = 1'b1;
    step();
    step();
    m0_ARVALID = 1'b0; s_ARREADY = 1'b0;
    for (int j = 0; j < P_TIMEOUT; j++) begin
      samp();
      chk("to_wait_rvalid", 64'(m0_RVALID), 64'd0);
      chk("to_wait_err", 64'(timeout_err), 64'd0);
      step();
    end
    samp();
    chk("to_rvalid", 64'(m0_RVALID), 64'd1);
    chk("to_rresp", 64'(m0_RRESP), 64'(2'b10));
    chk("to_rdata", m0_RDATA, 64'd0);
    chk("to_rlast", 64'(m0_RLAST), 64'd1);
    chk("to_s_rready", 64'(s_RREADY), 64'd0);
    chk("to_err", 64'(timeout_err), 64'd1);
    step();
    samp();
    chk("to_after_err", 64'(timeout_err), 64'd0);
    chk("to_after_grant", 64'(grant), 64'd0);
`endif

    // Randomized traffic against the model, then drain.
    do_reset();
    mst_state = '{0, 0}; mbeat = '{0, 0}; maddr = '{32'd0, 32'd0}; mprot = '{3'd0, 3'd0};
    mrdy = '{1'b0, 1'b0};
    slv_phase = 0; slv_k = 0; slv_nbeats = 1; slv_rv = 1'b0; slv_zero = 0; slv_addr = '0;
    slv_delay = 0;
    exp_busy = 1'b0; exp_owner = 0; exp_last = 1;
    for (int c = 0; c < 3000; c++) rand_cycle(1'b1);
    guard = 0;
    while ((mst_state[0] != 0 || mst_state[1] != 0 || exp_busy) && guard < 1000) begin
      rand_cycle(1'b0);
      guard++;
    end
    checks++;
    if (guard >= 1000) begin
      errors++;
      $display("FAIL drain: outstanding requests after %0d cycles, required none", guard);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
